avr_serial_tx: RTL and testbench

- Buffered UART transmitter driving the FPGA-to-AVR serial line (FPGA Tx => AVR Rx).
- Honours the AVR's "Rx buffer full" flow-control input and holds new frames while it is asserted.
- Sits beside the top level's serial pins; user logic pushes bytes in and the block serialises 8N1 (or 8E1, see optional feature), LSB first.

---
 rtl/avr_serial_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_avr_serial_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_serial_tx.sv
// avr_serial_tx
//   Buffered UART transmitter for the FPGA -> AVR serial line. Bytes pushed
//   by user logic are queued in a small FIFO and serialised 8N1, LSB first.
//   A new frame is only started while the AVR's "Rx buffer full" input
//   (block) is low; a frame already on the wire always runs to completion.
//
//   Optional feature: define AVR_SERIAL_TX_PARITY_EN to insert an even-parity
//   bit after the data bits (8E1 framing, 11 bit times per frame).
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   data      byte to send
//   new_data  write strobe (accepted when full=0, or when a pop frees a slot)
//   block     AVR Rx buffer full, asynchronous; 1 = hold new frames
//   tx        serial line to the AVR, idles high (flop output)
//   full      FIFO holds FIFO_DEPTH bytes
//   busy      frame in progress or FIFO non-empty
//   overflow  one-cycle pulse after a write was dropped because FIFO was full
//
// Parameters
//   CLK_PER_BIT  clk cycles per bit (>= 2)
//   FIFO_DEPTH   FIFO entries (power of two, >= 2)

module avr_serial_tx #(
  parameter int unsigned CLK_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       new_data,
  input  logic       block,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = FIFO_DEPTH[PTR_W:0];

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef AVR_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // block synchroniser (resets to "blocked")
  logic block_meta_q, block_s_q;

  // FIFO
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  // serialiser
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef AVR_SERIAL_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // registered status outputs
  logic full_q, busy_q, overflow_q;
  logic full_d, busy_d, overflow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_meta_q <= 1'b1;
      block_s_q    <= 1'b1;
    end else begin
      block_meta_q <= block;
      block_s_q    <= block_meta_q;
    end
  end

  // Next-state logic for FSM, FIFO bookkeeping and status flags
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    pop      = 1'b0;
`ifdef AVR_SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if ((count_q != '0) && !block_s_q) begin
          pop      = 1'b1;
          shift_d  = mem_q[rd_ptr_q];
`ifdef AVR_SERIAL_TX_PARITY_EN
          parity_d = ^mem_q[rd_ptr_q];
`endif
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef AVR_SERIAL_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // tx is registered, so load the next bit while shifting
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef AVR_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A pop in the same cycle frees a slot, so a write while full is taken
    push       = new_data && (!full_q || pop);
    overflow_d = new_data && full_q && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Flags are computed from next state so the outputs are plain flops
    full_d = (count_d == DEPTH_C);
    busy_d = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef AVR_SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
`ifdef AVR_SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign full     = full_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_avr_serial_tx.sv
// Testbench for avr_serial_tx (CLK_PER_BIT=4, FIFO_DEPTH=4).
// Accepted bytes are queued as expected frames; an independent line monitor
// decodes tx cycle by cycle and pops/compares each completed frame.

module tb_avr_serial_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef AVR_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = '0;
  logic       new_data = 1'b0;
  logic       block = 1'b0;
  logic       tx, full, busy, overflow;

  avr_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data(data), .new_data(new_data), .block(block),
    .tx(tx), .full(full), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [7:0] exp_q [$];
  longint     starts [$];
  longint     cyc = 0;
  logic       mon_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: frame = low start bit, 8 data bits LSB first,
  // [even parity], high stop bit; each level must hold for CPB cycles.
  initial begin
    int         c, p, ph;
    logic [7:0] rx;
    logic       par, bad;
    logic [7:0] e;
    c = 0; rx = '0; par = 1'b0; bad = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (!mon_active && tx === 1'b0) begin
          mon_active = 1'b1;
          c = 0; rx = '0; par = 1'b0; bad = 1'b0;
          starts.push_back(cyc);
        end else if (mon_active) begin
          c++;
        end
        if (mon_active) begin
          p  = c / CPB;
          ph = c % CPB;
          if (p == 0) begin
            if (tx !== 1'b0) bad = 1'b1;
          end else if (p <= 8) begin
            if (ph == 0) rx[p-1] = tx;
            else if (tx !== rx[p-1]) bad = 1'b1;
          end else if (p == 9 && NBITS == 11) begin
            if (ph == 0) par = tx;
            else if (tx !== par) bad = 1'b1;
          end else begin
            if (tx !== 1'b1) bad = 1'b1;
          end
          if (c == FRAME_CYC - 1) begin
            mon_active = 1'b0;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", {24'd0, rx}, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("rx_byte", {24'd0, rx}, {24'd0, e});
              check("frame_shape", {31'd0, bad}, 32'd0);
              if (NBITS == 11) check("parity_bit", {31'd0, par}, {31'd0, ^e});
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b, output logic accepted);
    @(negedge clk);
    accepted = !full;
    data     = b;
    new_data = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(posedge clk);
    #1;
    new_data = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy !== 1'b0 || mon_active || exp_q.size() != 0) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", {31'd0, (n >= limit)}, 32'd0);
  endtask

  initial begin
    logic acc;
    int   n;
    int   errs;

    // reset state
    #2 rst = 1'b1;
    #3;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single frame: latency and busy duration
    write_byte(8'hA5, acc);
    check("lat_pre_tx", {31'd0, tx}, 32'd1);
    check("lat_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("lat_tx_fall", {31'd0, tx}, 32'd0);
    repeat (FRAME_CYC - 1) @(posedge clk);
    #1;
    check("busy_last_cycle", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("busy_drop", {31'd0, busy}, 32'd0);
    check("tx_idle", {31'd0, tx}, 32'd1);
    wait_idle(200);

    // fill FIFO while blocked, then overflow
    @(negedge clk);
    block = 1'b1;
    repeat (3) @(posedge clk);
    write_byte(8'h01, acc);
    write_byte(8'h02, acc);
    write_byte(8'h03, acc);
    write_byte(8'h04, acc);
    check("full_set", {31'd0, full}, 32'd1);
    check("blocked_busy", {31'd0, busy}, 32'd1);
    check("blocked_tx", {31'd0, tx}, 32'd1);
    write_byte(8'h99, acc);
    check("ovf_not_accepted", {31'd0, acc}, 32'd0);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_full", {31'd0, full}, 32'd1);
    @(posedge clk); #1;
    check("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    repeat (5) @(posedge clk);
    check("blocked_tx_hold", {31'd0, tx}, 32'd1);

    // release block: start within 3 clocks, full clears on first pop
    starts.delete();
    @(negedge clk);
    block = 1'b0;
    n = 0;
    while (tx !== 1'b0 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("unblock_latency_ok", {31'd0, (n >= 1 && n <= 3)}, 32'd1);
    check("full_clear_on_pop", {31'd0, full}, 32'd0);
    wait_idle(600);
    check("b2b_frames", starts.size(), 32'd4);
    if (starts.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("b2b_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME_CYC + 1));
    end

    // block asserted mid-frame: frame completes, next byte held
    write_byte(8'hFF, acc);
    write_byte(8'h00, acc);
    repeat (20) @(posedge clk);
    @(negedge clk);
    block = 1'b1;
    n = 0;
    while (exp_q.size() != 1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("midblock_first_done", {31'd0, (n < 200)}, 32'd1);
    repeat (20) @(posedge clk);
    #1;
    check("midblock_hold_tx", {31'd0, tx}, 32'd1);
    check("midblock_hold_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    block = 1'b0;
    wait_idle(300);

    // randomized traffic with random block toggling
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) block = ~block;
      if (!full && $urandom_range(0, 2) == 0) begin
        data     = 8'($urandom);
        new_data = 1'b1;
        exp_q.push_back(data);
      end else begin
        new_data = 1'b0;
      end
    end
    @(negedge clk);
    new_data = 1'b0;
    block    = 1'b0;
    wait_idle(5000);

    // asynchronous reset during data bit 3
    write_byte(8'h3C, acc);
    write_byte(8'h5A, acc);
    n = 0;
    while (!mon_active && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_tx", {31'd0, tx}, 32'd1);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_full", {31'd0, full}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    check("post_rst_empty", errs, 32'd0);

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
